// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared types, digit width and the DIGITS legality helper
package bin2bcd_pkg;
    localparam int BCD_DIGIT_W = 4;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    // smallest d with 10^d > 2^width - 1
    function automatic int min_digits(input int width);
        longint unsigned lim;
        longint unsigned p;
        int d;
        lim = (64'd1 << width) - 64'd1;
        p = 64'd10;
        d = 1;
        for (int i = 0; i < 19; i++) begin
            if (p <= lim) begin
                p = p * 64'd10;
                d++;
            end
        end
        return d;
    endfunction
endpackage

// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if: request/result handshake between requester and converter
interface bin2bcd_seq_if #(parameter int WIDTH = 8, parameter int DIGITS = 3);
    import bin2bcd_pkg::*;
    logic in_valid;
    logic in_ready;
    logic [WIDTH-1:0] bin;
    logic out_valid;
    logic [BCD_DIGIT_W*DIGITS-1:0] bcd;
    logic [DIGITS-1:0] blank;
    modport master(output in_valid, bin, input in_ready, out_valid, bcd, blank);
    modport slave(input in_valid, bin, output in_ready, out_valid, bcd, blank);
endinterface

// File: rtl/bin2bcd_seq_dabble_digit.sv
// bcd_dabble_digit: per-digit "if >= 5 add 3" correction
module bcd_dabble_digit import bin2bcd_pkg::*; (
    input  logic [BCD_DIGIT_W-1:0] d,
    output logic [BCD_DIGIT_W-1:0] q
);
    assign q = d >= 4'd5 ? d + 4'd3 : d;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: one-bit-per-clock double-dabble converter with leading-zero blank mask
module bin2bcd_seq import bin2bcd_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int DIGITS = 3
) (
    input logic clk,
    input logic rst,
    bin2bcd_seq_if.slave bus
);
    localparam int BW = BCD_DIGIT_W * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);
    if (DIGITS < min_digits(WIDTH)) begin : g_chk
        $error("bin2bcd_seq: DIGITS too small for WIDTH");
    end
    state_t state, state_n;
    logic [WIDTH-1:0] sr;
    logic [BW-1:0] scr, scr_c, scr_n, bcd_q;
    logic [BW+WIDTH-1:0] sh;
    logic [DIGITS-1:0] blank_q, blank_n;
    logic [CW-1:0] cnt;
    logic last, z;
    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        bcd_dabble_digit u_dig (
            .d(scr[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
            .q(scr_c[BCD_DIGIT_W*i +: BCD_DIGIT_W])
        );
    end
    assign sh = {scr_c, sr} << 1;
    assign scr_n = sh[BW+WIDTH-1:WIDTH];
    assign last = cnt == CW'(1);
    // a digit is blank when it and every digit above it are zero
    always_comb begin
        blank_n = '0;
        z = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            z = z && (scr_n[BCD_DIGIT_W*k +: BCD_DIGIT_W] == '0);
            blank_n[k] = z;
        end
    end
    always_comb begin
        state_n = state == IDLE  ? (bus.in_valid ? SHIFT : IDLE) :
                  state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sr <= '0;
            scr <= '0;
            cnt <= '0;
            bcd_q <= '0;
            blank_q <= BLANK_RST;
        end else begin
            state <= state_n;
            if (state == IDLE && bus.in_valid) begin
                sr <= bus.bin;
                scr <= '0;
                cnt <= CW'(WIDTH);
            end else if (state == SHIFT) begin
                sr <= sh[WIDTH-1:0];
                scr <= scr_n;
                cnt <= cnt - CW'(1);
                if (last) begin
                    bcd_q <= scr_n;
                    blank_q <= blank_n;
                end
            end
        end
    end
    assign bus.in_ready = rst && state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.bcd = bcd_q;
    assign bus.blank = blank_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: randomized and directed checks of bin2bcd_seq against a decimal model
module tb_bin2bcd_seq;
    localparam int WIDTH = 8;
    localparam int DIGITS = 3;
    localparam int BW = 4 * DIGITS;
    localparam logic [DIGITS-1:0] BLANK_RST = 3'b110;
    logic clk = 1'b0;
    logic rst;
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int q_val[$];
    int q_due[$];
    logic [BW-1:0] held_bcd;
    logic [DIGITS-1:0] held_blank;

    bin2bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();
    bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] m_bcd(input int v);
        logic [BW-1:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [DIGITS-1:0] m_blank(input int v);
        logic [DIGITS-1:0] r;
        int p;
        r = '0;
        p = 10;
        for (int i = 1; i < DIGITS; i++) begin
            r[i] = v < p;
            p = p * 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: idle iff nothing in flight; result due WIDTH+1 cycles after the accept
    always @(negedge clk) begin : cmp_p
        logic rdy;
        logic exp_ov;
        cyc++;
        if (!rst) begin
            q_val.delete();
            q_due.delete();
            held_bcd = '0;
            held_blank = BLANK_RST;
            chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
            chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
            chk("rst_bcd", 32'(bus.bcd), 32'(held_bcd));
            chk("rst_blank", 32'(bus.blank), 32'(held_blank));
        end else begin
            rdy = q_val.size() == 0;
            chk("in_ready", 32'(bus.in_ready), 32'(rdy));
            if (rdy && bus.in_valid) begin
                q_val.push_back(int'(bus.bin));
                q_due.push_back(cyc + WIDTH + 1);
            end
            exp_ov = q_due.size() > 0 && q_due[0] == cyc;
            chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
            if (exp_ov) begin
                held_bcd = m_bcd(q_val[0]);
                held_blank = m_blank(q_val[0]);
                void'(q_val.pop_front());
                void'(q_due.pop_front());
            end
            chk("bcd", 32'(bus.bcd), 32'(held_bcd));
            chk("blank", 32'(bus.blank), 32'(held_blank));
        end
    end

    task automatic convert(input logic [WIDTH-1:0] v, input logic [BW-1:0] eb, input logic [DIGITS-1:0] ebl);
        int n;
        @(posedge clk);
        #1 bus.in_valid = 1'b1;
        bus.bin = v;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 50);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        bus.bin = WIDTH'($urandom);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 50);
        chk("latency", 32'(n), 32'(WIDTH + 1));
        chk("conv_bcd", 32'(bus.bcd), 32'(eb));
        chk("conv_blank", 32'(bus.blank), 32'(ebl));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.bin = '0;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        convert(8'd0, 12'h000, 3'b110);
        convert(8'd255, 12'h255, 3'b000);
        convert(8'd9, 12'h009, 3'b110);
        convert(8'd10, 12'h010, 3'b100);
        convert(8'd100, 12'h100, 3'b000);
        // held request with a stepping source value
        @(posedge clk);
        #1 bus.in_valid = 1'b1;
        bus.bin = WIDTH'($urandom);
        repeat (45) begin
            @(posedge clk);
            #1 bus.bin = bus.bin + 1'b1;
        end
        bus.in_valid = 1'b0;
        repeat (12) @(posedge clk);
        // reset in the middle of a conversion
        convert(8'd255, 12'h255, 3'b000);
        @(posedge clk);
        #1 bus.in_valid = 1'b1;
        bus.bin = 8'd200;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        bus.bin = WIDTH'($urandom);
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("abort_bcd", 32'(bus.bcd), 32'h000);
        chk("abort_blank", 32'(bus.blank), 32'(3'b110));
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        convert(8'd200, 12'h200, 3'b000);
        for (int v = 0; v < 256; v++) convert(WIDTH'(v), m_bcd(v), m_blank(v));
        for (int k = 0; k < 40; k++) begin : rnd
            int v;
            v = int'($urandom_range(0, 255));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            convert(WIDTH'(v), m_bcd(v), m_blank(v));
        end
        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method.
- Sits directly downstream of the counter: takes its WIDTH-bit count output and produces DIGITS packed BCD digits plus a leading-zero blank mask for the 7-segment display driver.
- Converts one value per request, one bit per clock, over a valid/ready handshake.

Parameters:
- WIDTH, 8, binary input width; must match the counter's WIDTH.
- DIGITS, 3, number of BCD output digits. Elaboration-time check: 10^DIGITS > 2^WIDTH - 1.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  request; bin is valid.
- in_ready  out  1  converter is idle and can accept a request.
- bin  in  WIDTH  binary value to convert, typically the counter's count output.
- out_valid  out  1  one-cycle pulse: bcd and blank have just been updated.
- bcd  out  4*DIGITS  packed BCD result; digit 0 (units) is in bits [3:0].
- blank  out  DIGITS  bit i high means digit i is a leading zero. Bit 0 is always 0.

Behaviour:
- Reset (rst low, asynchronous):
  - state goes to IDLE.
  - bcd = 0, blank = {DIGITS-1{1}, 0}, out_valid = 0.
  - Internal shift register, scratch BCD and bit counter are cleared.
  - in_ready = 0 while rst is low. It goes to 1 from the first cycle after deassertion.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - On an edge where in_valid = 1: capture bin into the shift register, zero the scratch BCD, load the bit counter with WIDTH, go to SHIFT.
  - bin is sampled only at this accept edge; later changes have no effect.
- SHIFT:
  - in_ready = 0.
  - Each edge: every scratch digit >= 5 gets +3, all digits in parallel. Then {scratch, shiftreg} shifts left by 1. The bit counter decrements.
  - On the edge where the counter reaches 0 (the WIDTH-th shift edge): load bcd from the final scratch, load blank, go to DONE.
- DONE:
  - out_valid = 1 for exactly this one cycle; in_ready = 0.
  - Next edge returns to IDLE unconditionally.
- Latency and throughput:
  - Accept edge E0, shift edges E1..E_WIDTH.
  - out_valid is high in the cycle after E_WIDTH.
  - Next accept can occur at edge E_(WIDTH+2), giving one conversion per WIDTH+2 cycles.
  - in_valid held high continuously produces back-to-back conversions at that rate.
- Holding:
  - bcd and blank keep their value until the next conversion completes; they never show partial results.
  - in_valid while in SHIFT or DONE is ignored. No queuing; the upstream must hold the request until accepted.
- Blank computation:
  - blank[i] = 1 iff digits i..DIGITS-1 are all zero, for i >= 1.
  - blank[0] = 0.
- Width and arithmetic:
  - Scratch is 4*DIGITS bits; add-3 is applied per 4-bit digit with no carry between digits.
  - No digit exceeds 9 once the DIGITS check is satisfied.
- Reset mid-conversion:
  - The conversion is aborted and returns to reset values. No out_valid pulse is produced.
- Boundary values:
  - bin = 0 gives bcd = 0 with upper digits blanked.
  - bin = 2^WIDTH - 1 gives the full-scale decimal result with no overflow.

Decomposition:
- Package bin2bcd_pkg holds:
  - the state enum typedef (IDLE, SHIFT, DONE);
  - a function computing the minimum legal DIGITS from WIDTH, used by the elaboration check;
  - localparam BCD_DIGIT_W = 4.
- Sub-module bcd_dabble_digit: combinational 4-bit "if >= 5 add 3" corrector, instantiated DIGITS times in a generate loop.

Test Plan:
- After reset release, pulse in_valid with bin = 8'd0 -> out_valid in the cycle after edge E8; bcd = 12'h000, blank = 3'b110.
- bin = 8'd255 -> bcd = 12'h255, blank = 3'b000, exactly WIDTH+1 cycles after acceptance; in_ready is low for those cycles.
- bin = 8'd9, then bin = 8'd10, then bin = 8'd100 -> bcd = 009 / blank 110, bcd = 010 / blank 100, bcd = 100 / blank 000.
- in_valid held high with bin stepping via the counter -> accepts every 10 cycles; each result equals the value sampled at its accept edge; bin changes during SHIFT do not alter the result.
- Assert rst at the 4th shift edge of bin = 8'd200 -> bcd and blank return to reset values immediately (asynchronously); no out_valid; after release, a new request for 8'd200 gives 12'h200.
- Exhaustive sweep of 0..255 against a decimal reference model -> every result matches; out_valid is never wider than 1 cycle.
